// File: rtl/shift_register_rx_if.sv
// Bundle between the serial transmitter, the receiver and the word consumer.
// The master modport is the driving environment; slave is the receiver.
interface shift_register_rx_if #(
    parameter int WIDTH = 32
);
    logic             SIN;
    logic             SIN_STROBE;
    logic             FRAME;
    logic [WIDTH-1:0] DOUT;
    logic             DOUT_VALID;
    logic             DOUT_READY;
    logic             RX_BUSY;
    logic             OVERRUN;
    logic             FRAME_ERR;

    modport master (
        output SIN, SIN_STROBE, FRAME, DOUT_READY,
        input  DOUT, DOUT_VALID, RX_BUSY, OVERRUN, FRAME_ERR
    );

    modport slave (
        input  SIN, SIN_STROBE, FRAME, DOUT_READY,
        output DOUT, DOUT_VALID, RX_BUSY, OVERRUN, FRAME_ERR
    );
endinterface

// File: rtl/shift_register_rx.sv
// Serial-to-parallel receiver: assembles WIDTH strobed bits LSB-first and
// hands each word to a single-entry valid/ready output register.
module shift_register_rx #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic               CLK,
    input  logic               RESET_N,
    shift_register_rx_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RECV     = 2'd1;
    localparam logic [1:0] ST_COMPLETE = 2'd2;
    localparam logic [1:0] ST_WAIT_END = 2'd3;

    logic [SYNC_STAGES-1:0] sin_sync_q, sin_sync_d;
    logic [SYNC_STAGES-1:0] stb_sync_q, stb_sync_d;
    logic [SYNC_STAGES-1:0] frm_sync_q, frm_sync_d;
    logic                   s_sin, s_stb, s_frame;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    count_inc_s;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             rx_busy_q, rx_busy_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;

    // Synchronizer chains: all three inputs get the same depth to stay aligned.
    always_comb begin
        sin_sync_d    = sin_sync_q;
        stb_sync_d    = stb_sync_q;
        frm_sync_d    = frm_sync_q;
        sin_sync_d[0] = bus.SIN;
        stb_sync_d[0] = bus.SIN_STROBE;
        frm_sync_d[0] = bus.FRAME;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sin_sync_d[i] = sin_sync_q[i-1];
            stb_sync_d[i] = stb_sync_q[i-1];
            frm_sync_d[i] = frm_sync_q[i-1];
        end
    end

    assign s_sin   = sin_sync_q[SYNC_STAGES-1];
    assign s_stb   = stb_sync_q[SYNC_STAGES-1];
    assign s_frame = frm_sync_q[SYNC_STAGES-1];

    assign count_inc_s = count_q + {{(CW-1){1'b0}}, 1'b1};

    // Receive FSM, shift register and output-register handoff.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        shreg_d     = shreg_q;
        dout_d      = dout_q;
        overrun_d   = 1'b0;
        frame_err_d = 1'b0;

        if (dout_valid_q && bus.DOUT_READY) begin
            dout_valid_d = 1'b0;
        end else begin
            dout_valid_d = dout_valid_q;
        end

        case (state_q)
            // IDLE and RECV share the bit-capture path; count is always 0 in IDLE.
            ST_IDLE, ST_RECV: begin
                if (s_frame) begin
                    state_d = ST_RECV;
                    if (s_stb) begin
                        for (int i = 0; i < WIDTH; i++) begin
                            if (count_q == CW'(i)) begin
                                shreg_d[i] = s_sin;
                            end else begin
                                shreg_d[i] = shreg_q[i];
                            end
                        end
                        count_d = count_inc_s;
                        if (count_inc_s == CW'(WIDTH)) begin
                            state_d = ST_COMPLETE;
                        end else begin
                            state_d = ST_RECV;
                        end
                    end else begin
                        count_d = count_q;
                    end
                end else if (state_q == ST_RECV) begin
                    frame_err_d = 1'b1;
                    count_d     = {CW{1'b0}};
                    shreg_d     = {WIDTH{1'b0}};
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMPLETE: begin
                if (!dout_valid_q || bus.DOUT_READY) begin
                    dout_d       = shreg_q;
                    dout_valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
                count_d = {CW{1'b0}};
                shreg_d = {WIDTH{1'b0}};
                if (s_frame) begin
                    state_d = ST_WAIT_END;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_END: begin
                if (s_frame) begin
                    state_d = ST_WAIT_END;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = {CW{1'b0}};
                shreg_d = {WIDTH{1'b0}};
            end
        endcase

        rx_busy_d = (state_d == ST_RECV) || (state_d == ST_WAIT_END);
    end

    // Synchronizer flops.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sin_sync_q <= {SYNC_STAGES{1'b0}};
            stb_sync_q <= {SYNC_STAGES{1'b0}};
            frm_sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sin_sync_q <= sin_sync_d;
            stb_sync_q <= stb_sync_d;
            frm_sync_q <= frm_sync_d;
        end
    end

    // FSM state, datapath and registered status outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            count_q      <= {CW{1'b0}};
            shreg_q      <= {WIDTH{1'b0}};
            dout_q       <= {WIDTH{1'b0}};
            dout_valid_q <= 1'b0;
            rx_busy_q    <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            shreg_q      <= shreg_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            rx_busy_q    <= rx_busy_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.DOUT       = dout_q;
    assign bus.DOUT_VALID = dout_valid_q;
    assign bus.RX_BUSY    = rx_busy_q;
    assign bus.OVERRUN    = overrun_q;
    assign bus.FRAME_ERR  = frame_err_q;
endmodule

// File: doc/shift_register_rx.md
Name: shift_register_rx

Overview:
- Serial-to-parallel receiver; the stage directly downstream of the 32-bit parallel-load serial transmitter.
- Assembles WIDTH bits (LSB first) from a serial line qualified by a per-bit strobe and a frame-active level.
- Presents each completed word on a valid/ready parallel interface.
- Has one word of output buffering, so the next frame can shift in while the previous word waits for its consumer.

Parameters:
- WIDTH, 32: bits per frame; the word width.
- SYNC_STAGES, 2: input synchronizer depth applied equally to SIN, SIN_STROBE and FRAME; legal range 1..4.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- SIN  input  1  serial data bit.
- SIN_STROBE  input  1  bit qualifier; SIN is sampled on every synchronized cycle where this is high.
- FRAME  input  1  high for the duration of a transmission (driven from transmitter busy).
- DOUT  output  WIDTH  received word; bit 0 = first bit received.
- DOUT_VALID  output  1  DOUT holds an unconsumed word.
- DOUT_READY  input  1  consumer accepts DOUT when DOUT_VALID && DOUT_READY.
- RX_BUSY  output  1  high in states RECV and WAIT_END.
- OVERRUN  output  1  one-cycle pulse: a completed word was dropped.
- FRAME_ERR  output  1  one-cycle pulse: frame ended short.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - State IDLE; shift register, bit counter and sync flops cleared.
  - Outputs: DOUT=0, DOUT_VALID=0, RX_BUSY=0, OVERRUN=0, FRAME_ERR=0.
  - Reset mid-frame discards the partial word and any held output.
- Synchronization: SIN, SIN_STROBE and FRAME each pass through SYNC_STAGES flops. All FSM logic uses only the synchronized copies (s_sin, s_stb, s_frame), so the three stay cycle-aligned.
- Bit counter is $clog2(WIDTH+1) bits wide and counts 0..WIDTH.
- IDLE:
  - Counter=0.
  - s_frame=1 -> RECV.
  - A strobe in the same cycle that s_frame rises is sampled as bit 0.
  - Strobes while s_frame=0 are ignored.
- RECV:
  - On each s_stb=1: shreg[count] <= s_sin; count <= count+1.
  - When the strobe takes count to WIDTH -> COMPLETE (next cycle).
  - s_frame=0 with count<WIDTH: FRAME_ERR pulses, partial word discarded, -> IDLE. A strobe in that same cycle is ignored.
- COMPLETE (one cycle), handing the word to the output register:
  - If DOUT_VALID=0, or DOUT_VALID && DOUT_READY in this cycle: DOUT <= shreg, DOUT_VALID <= 1.
  - Otherwise: OVERRUN pulses, the word is dropped, and DOUT/DOUT_VALID are unchanged.
  - Then -> WAIT_END if s_frame=1, else IDLE.
- WAIT_END:
  - Extra strobes are ignored (no error).
  - s_frame=0 -> IDLE.
  - A new frame can start only after s_frame has been seen low for at least one cycle.
- Output handshake:
  - DOUT_VALID falls the cycle after DOUT_VALID && DOUT_READY, unless COMPLETE reloads it in that same cycle; then it stays 1 with the new DOUT.
  - DOUT is stable while DOUT_VALID=1 and not accepted.
  - DOUT_READY has no effect while DOUT_VALID=0.
- Latency: DOUT_VALID rises SYNC_STAGES+2 CLK cycles after the raw strobe of the final bit.
- RX_BUSY = (state==RECV || state==WAIT_END).
- OVERRUN and FRAME_ERR are registered, one cycle wide, and never asserted together.

Test Plan:
1. Reset, then frame with 32 strobes carrying 0xA5C3_0F81 LSB-first, DOUT_READY=1 -> DOUT=0xA5C30F81, DOUT_VALID=1 exactly SYNC_STAGES+2 cycles after the last strobe; accepted next cycle; RX_BUSY low after FRAME falls.
2. Two back-to-back frames 0x00000001 then 0xFFFFFFFE with DOUT_READY=0 throughout -> first word held; OVERRUN pulses once at second completion; DOUT stays 0x00000001.
3. Same two frames, DOUT_READY raised in the second frame's COMPLETE cycle -> no OVERRUN; DOUT_VALID stays 1 and DOUT becomes 0xFFFFFFFE.
4. FRAME dropped after 17 strobes -> FRAME_ERR one-cycle pulse, DOUT_VALID stays 0. Next full frame 0x12345678 is received correctly, with no stale bits.
5. 35 strobes within one FRAME -> word = first 32 bits, no error; strobes 33-35 ignored; RX_BUSY held until FRAME low.
6. RESET_N asserted asynchronously mid-frame at bit 10, and again while DOUT_VALID=1 -> all outputs 0 immediately. A full frame after release receives correctly.
